lifo_pop_streamer: RTL and testbench

Read-side controller for the team's synchronous LIFO. It accepts a "pop N words" command, issues `rdreq` pulses to the LIFO while honouring its registered `empty` flag and one-cycle read latency, and delivers the popped words as a valid/ready stream with `last` marking the final word. It sits between a LIFO instance and any downstream consumer that applies backpressure.

---
 rtl/lifo_pop_streamer_if.sv | 35 +++
 rtl/lifo_pop_streamer.sv | 119 +++++++++++
 tb/tb_lifo_pop_streamer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lifo_pop_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : lifo_pop_streamer_if
// Description : Command, LIFO read-port and output-stream signals of the
//               LIFO pop streamer, bundled with DUT/driver modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface lifo_pop_streamer_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
);
    logic              cmd_valid_i;
    logic [AWIDTH:0]   cmd_len_i;
    logic              cmd_ready_o;
    logic              lifo_rdreq_o;
    logic [DWIDTH-1:0] lifo_q_i;
    logic              lifo_empty_i;
    logic [DWIDTH-1:0] data_o;
    logic              valid_o;
    logic              last_o;
    logic              ready_i;
    logic              busy_o;
    logic              done_o;

    modport slave (
        input  cmd_valid_i, cmd_len_i, lifo_q_i, lifo_empty_i, ready_i,
        output cmd_ready_o, lifo_rdreq_o, data_o, valid_o, last_o, busy_o, done_o
    );

    modport master (
        output cmd_valid_i, cmd_len_i, lifo_q_i, lifo_empty_i, ready_i,
        input  cmd_ready_o, lifo_rdreq_o, data_o, valid_o, last_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/lifo_pop_streamer.sv
`default_nettype none
// ============================================================================
// Module      : lifo_pop_streamer
// Description : Pops N words from a synchronous LIFO and streams them out on
//               a valid/ready interface with a last marker.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_pop_streamer #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  wire logic          clk_i,
    input  wire logic          srst_i,
    lifo_pop_streamer_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_POP   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    logic [1:0]        r_state;
    logic [AWIDTH:0]   r_remaining;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;
    logic [DWIDTH-1:0] r_buf_data [2];
    logic [1:0]        r_buf_last;
    logic [1:0]        r_count;

    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_rdreq;
    logic [2:0]        w_occ;
    logic              w_wr_sel;

    assign w_accept = (r_state == c_ST_IDLE) && bus.cmd_valid_i;
    assign w_pop    = (r_count != 2'd0) && bus.ready_i;
    assign w_push   = r_inflight;

    // Occupancy after this cycle's handshake; a new request only fits below two.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rdreq = (r_state == c_ST_POP) && (r_remaining != '0) &&
                     !bus.lifo_empty_i && (w_occ < 3'd2);

    // Returning word lands behind whatever survives this cycle's pop.
    assign w_wr_sel = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state         <= c_ST_IDLE;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_rdreq;
            r_inflight_last <= w_rdreq && (r_remaining == {{AWIDTH{1'b0}}, 1'b1});
            if (w_rdreq) begin
                r_remaining <= r_remaining - 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (bus.cmd_len_i == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_remaining <= bus.cmd_len_i;
                            r_state     <= c_ST_POP;
                        end
                    end
                end
                c_ST_POP: begin
                    if (w_rdreq && (r_remaining == {{AWIDTH{1'b0}}, 1'b1})) begin
                        r_state <= c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    if (w_pop && r_buf_last[0]) begin
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Two-entry shift buffer; entry 0 is always the head presented downstream.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last    <= 2'b00;
            r_count       <= 2'd0;
        end else begin
            if (w_pop) begin
                r_buf_data[0] <= r_buf_data[1];
                r_buf_last[0] <= r_buf_last[1];
            end
            if (w_push) begin
                r_buf_data[w_wr_sel] <= bus.lifo_q_i;
                r_buf_last[w_wr_sel] <= r_inflight_last;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.cmd_ready_o  = (r_state == c_ST_IDLE);
    assign bus.lifo_rdreq_o = w_rdreq;
    assign bus.data_o       = r_buf_data[0];
    assign bus.valid_o      = (r_count != 2'd0);
    assign bus.last_o       = r_buf_last[0] && (r_count != 2'd0);
    assign bus.busy_o       = (r_state != c_ST_IDLE);
    assign bus.done_o       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lifo_pop_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lifo_pop_streamer
// Description : Self-checking bench with a behavioural LIFO and a stack-based
//               reference of the expected pop order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo_pop_streamer;

    localparam int DW = 8;
    localparam int AW = 4;

    logic clk  = 1'b0;
    logic srst = 1'b0;
    always #5 clk = ~clk;

    lifo_pop_streamer_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    lifo_pop_streamer #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    // Behavioural LIFO: registered read data, empty derived from the registered pointer.
    logic [DW-1:0] lifo_mem [0:63];
    logic [DW-1:0] pend [0:15];
    int            pend_n = 0;
    int            lifo_sp = 0;
    int            lifo_nbase;
    logic [DW-1:0] lifo_q = '0;
    logic          wr_go = 1'b0;
    logic          clr_go = 1'b0;
    logic          rd_ok;

    assign rd_ok            = bus.lifo_rdreq_o && (lifo_sp > 0);
    assign lifo_nbase       = clr_go ? 0 : (rd_ok ? lifo_sp - 1 : lifo_sp);
    assign bus.lifo_q_i     = lifo_q;
    assign bus.lifo_empty_i = (lifo_sp == 0);

    always @(posedge clk) begin
        if (rd_ok && !clr_go) lifo_q <= lifo_mem[lifo_sp-1];
        if (wr_go) for (int i = 0; i < pend_n; i++) lifo_mem[lifo_nbase+i] <= pend[i];
        lifo_sp <= lifo_nbase + (wr_go ? pend_n : 0);
    end

    // Monitor: logs handshakes and protocol counters at the falling edge.
    int   cyc = 0;
    int   rd_cnt = 0, bad_rd = 0, occ = 0, occ_bad = 0, stab_bad = 0;
    int   valid_cnt = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
    logic done_rdy = 1'b0;
    logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_rst = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    int            hs_cyc_q [$];
    int            rd_cyc_q [$];
    logic          hs;

    assign hs = bus.valid_o && bus.ready_i;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.cmd_valid_i && bus.cmd_ready_o && !srst) acc_cyc <= cyc;
        if (bus.lifo_rdreq_o) begin
            rd_cnt <= rd_cnt + 1;
            rd_cyc_q.push_back(cyc);
            if (bus.lifo_empty_i) bad_rd <= bad_rd + 1;
        end
        if (hs) begin
            got_d.push_back(bus.data_o);
            got_l.push_back(bus.last_o);
            hs_cyc_q.push_back(cyc);
        end
        if (bus.valid_o) valid_cnt <= valid_cnt + 1;
        if (bus.done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_rdy <= bus.cmd_ready_o;
        end
        if (srst) begin
            occ <= 0;
        end else begin
            occ <= occ + int'(bus.lifo_rdreq_o) - int'(hs);
            if (occ + int'(bus.lifo_rdreq_o) - int'(hs) > 2) occ_bad <= occ_bad + 1;
        end
        if (prev_v && !prev_r && !prev_rst && !srst &&
            !(bus.valid_o && bus.data_o == prev_d && bus.last_o == prev_l))
            stab_bad <= stab_bad + 1;
        prev_v   <= bus.valid_o;
        prev_r   <= bus.ready_i;
        prev_d   <= bus.data_o;
        prev_l   <= bus.last_o;
        prev_rst <= srst;
    end

    int            cmp_cnt = 0;
    int            err_cnt = 0;
    logic [DW-1:0] ref_stack [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stage(input logic [DW-1:0] w);
        pend[pend_n] = w;
        pend_n++;
    endtask

    task automatic lifo_commit(input bit clear);
        clr_go = clear;
        wr_go  = 1'b1;
        if (clear) ref_stack.delete();
        for (int i = 0; i < pend_n; i++) ref_stack.push_back(pend[i]);
        tick();
        clr_go = 1'b0;
        wr_go  = 1'b0;
        pend_n = 0;
    endtask

    task automatic drive_ready(input int mode, input int n);
        if (mode == 0)      bus.ready_i = 1'b1;
        else if (mode == 1) bus.ready_i = ((n % 2) == 0);
        else                bus.ready_i = ($urandom_range(0, 2) != 0);
    endtask

    // Issue one command, wait (bounded) for done, compare against the reference stack.
    task automatic run_cmd(input string tag, input int len, input int mode, input bit timing);
        logic [DW-1:0] exp_q [$];
        int b_hs, b_rd, b_done, b_bad, b_occ, b_stab, n, t, lasths;
        for (int i = 0; i < len; i++) exp_q.push_back(ref_stack.pop_back());
        b_hs = got_d.size(); b_rd = rd_cnt; b_done = done_cnt;
        b_bad = bad_rd; b_occ = occ_bad; b_stab = stab_bad;
        bus.cmd_len_i   = (AW+1)'(len);
        bus.cmd_valid_i = 1'b1;
        drive_ready(mode, 0);
        tick();
        bus.cmd_valid_i = 1'b0;
        n = 1;
        while (done_cnt == b_done && n < 400) begin
            drive_ready(mode, n);
            tick();
            n++;
        end
        bus.ready_i = 1'b1;
        t = acc_cyc;
        check({tag, "_done_count"}, 32'(done_cnt - b_done), 32'd1);
        check({tag, "_words"}, 32'(got_d.size() - b_hs), 32'(len));
        for (int i = 0; i < len && (b_hs + i) < got_d.size(); i++) begin
            check({tag, "_data"}, 32'(got_d[b_hs+i]), 32'(exp_q[i]));
            check({tag, "_last"}, 32'(got_l[b_hs+i]), 32'(i == len - 1));
        end
        lasths = (hs_cyc_q.size() > b_hs) ? hs_cyc_q[hs_cyc_q.size()-1] : -10;
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(lasths + 1));
        check({tag, "_ready_at_done"}, 32'(done_rdy), 32'd1);
        check({tag, "_rdreq_count"}, 32'(rd_cnt - b_rd), 32'(len));
        check({tag, "_rdreq_empty"}, 32'(bad_rd - b_bad), 32'd0);
        check({tag, "_occupancy"}, 32'(occ_bad - b_occ), 32'd0);
        check({tag, "_stable"}, 32'(stab_bad - b_stab), 32'd0);
        if (timing && rd_cyc_q.size() >= b_rd + len && hs_cyc_q.size() > b_hs) begin
            check({tag, "_first_rdreq"}, 32'(rd_cyc_q[b_rd]), 32'(t + 1));
            check({tag, "_last_rdreq"}, 32'(rd_cyc_q[b_rd+len-1]), 32'(t + len));
            check({tag, "_first_valid"}, 32'(hs_cyc_q[b_hs]), 32'(t + 3));
            check({tag, "_done_at"}, 32'(done_cyc), 32'(t + len + 3));
        end
    endtask

    initial begin
        int b_hs, b_rd, b_done, b_valid, b_sp, n, len;

        // Reset held two cycles with random inputs
        srst            = 1'b1;
        bus.cmd_valid_i = 1'($urandom);
        bus.cmd_len_i   = (AW+1)'($urandom);
        bus.ready_i     = 1'($urandom);
        tick();
        bus.cmd_valid_i = 1'($urandom);
        bus.cmd_len_i   = (AW+1)'($urandom);
        bus.ready_i     = 1'($urandom);
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("rst_rdreq", 32'(bus.lifo_rdreq_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_last", 32'(bus.last_o), 32'd0);
        check("rst_data", 32'(bus.data_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        tick();
        srst            = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_len_i   = '0;
        bus.ready_i     = 1'b1;
        tick();

        // Basic pop with full-rate timing
        for (int i = 1; i <= 5; i++) stage(DW'(i));
        lifo_commit(1'b1);
        run_cmd("basic", 3, 0, 1'b1);

        // Backpressure with alternating ready
        for (int i = 0; i < 8; i++) stage(DW'(8'h10 + i));
        lifo_commit(1'b1);
        run_cmd("bp", 8, 1, 1'b0);

        // Empty stall, then refill mid-command
        stage(8'h21); stage(8'h22);
        lifo_commit(1'b1);
        b_hs = got_d.size(); b_rd = rd_cnt; b_done = done_cnt;
        bus.cmd_len_i   = (AW+1)'(4);
        bus.cmd_valid_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("stall_words", 32'(got_d.size() - b_hs), 32'd2);
        check("stall_rdreq", 32'(rd_cnt - b_rd), 32'd2);
        check("stall_busy", 32'(bus.busy_o), 32'd1);
        check("stall_no_done", 32'(done_cnt - b_done), 32'd0);
        stage(8'hAA); stage(8'hBB);
        lifo_commit(1'b0);
        n = 0;
        while (done_cnt == b_done && n < 50) begin tick(); n++; end
        check("stall_done", 32'(done_cnt - b_done), 32'd1);
        check("stall_total", 32'(got_d.size() - b_hs), 32'd4);
        if (got_d.size() >= b_hs + 4) begin
            check("stall_w0", 32'(got_d[b_hs+0]), 32'h22);
            check("stall_w1", 32'(got_d[b_hs+1]), 32'h21);
            check("stall_w2", 32'(got_d[b_hs+2]), 32'hBB);
            check("stall_w3", 32'(got_d[b_hs+3]), 32'hAA);
            check("stall_l2", 32'(got_l[b_hs+2]), 32'd0);
            check("stall_l3", 32'(got_l[b_hs+3]), 32'd1);
            check("stall_done_cyc", 32'(done_cyc), 32'(hs_cyc_q[hs_cyc_q.size()-1] + 1));
        end
        ref_stack.delete();

        // Zero-length command
        stage(8'h5A); stage(8'h5B);
        lifo_commit(1'b1);
        b_rd = rd_cnt; b_done = done_cnt; b_valid = valid_cnt; b_sp = lifo_sp;
        bus.cmd_len_i   = '0;
        bus.cmd_valid_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("zero_done", 32'(done_cnt - b_done), 32'd1);
        check("zero_done_cyc", 32'(done_cyc), 32'(acc_cyc + 1));
        check("zero_rdreq", 32'(rd_cnt - b_rd), 32'd0);
        check("zero_valid", 32'(valid_cnt - b_valid), 32'd0);
        check("zero_usedw", 32'(lifo_sp), 32'(b_sp));

        // Reset in the cycle after the second read request (downstream stalled)
        for (int i = 1; i <= 8; i++) stage(DW'(8'h30 + i));
        lifo_commit(1'b1);
        b_hs = got_d.size(); b_rd = rd_cnt; b_done = done_cnt;
        bus.ready_i     = 1'b0;
        bus.cmd_len_i   = (AW+1)'(5);
        bus.cmd_valid_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        n = 0;
        while ((rd_cnt - b_rd) < 2 && n < 20) begin tick(); n++; end
        check("rstmid_reach", 32'(rd_cnt - b_rd), 32'd2);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        @(negedge clk);
        check("rstmid_valid", 32'(bus.valid_o), 32'd0);
        check("rstmid_busy", 32'(bus.busy_o), 32'd0);
        check("rstmid_done", 32'(bus.done_o), 32'd0);
        tick();
        bus.ready_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rstmid_no_output", 32'(got_d.size() - b_hs), 32'd0);
        check("rstmid_no_done", 32'(done_cnt - b_done), 32'd0);
        check("rstmid_pops", 32'(rd_cnt - b_rd), 32'd2);
        void'(ref_stack.pop_back());
        void'(ref_stack.pop_back());
        run_cmd("resume", 1, 0, 1'b1);

        // Randomised commands with random backpressure
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len + $urandom_range(0, 3); i++) stage(DW'($urandom));
            lifo_commit(1'b1);
            run_cmd("rand", len, 2, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
